// File: rtl/jtag_pkg.sv
// Shared constants and types for the JTAG USER-chain front end.
package jtag_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int COUNT_WIDTH = 16;
  localparam int RB_WIDTH    = COUNT_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/jtag_readback_shifter.sv
// Capture/shift register that returns {framing_error, word_count} on tdo, LSB first.
// Instantiated by jtag_deserializer only when JTAG_READBACK_EN is defined.
module jtag_readback_shifter
  import jtag_pkg::*;
#(
  parameter int WIDTH = RB_WIDTH
) (
  input  logic             tck,
  input  logic             test_logic_reset,
  input  logic             cap_i,
  input  logic             shift_i,
  input  logic             tdi_i,
  input  logic [WIDTH-1:0] load_i,
  output logic             tdo_o
);

  logic [WIDTH-1:0] rb_q, rb_d;

  always_comb begin
    rb_d = rb_q;
    if (cap_i) begin
      rb_d = load_i;
    end else if (shift_i) begin
      rb_d = {tdi_i, rb_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      rb_q <= '0;
    end else begin
      rb_q <= rb_d;
    end
  end

  // Bit 0 is presented right after Capture-DR so the host's first falling-edge sample is count[0].
  assign tdo_o = rb_q[0];

endmodule

// File: rtl/jtag_deserializer.sv
// USER-chain DR shift stream to parallel words, with end-of-scan, framing error and word count.
// Optional build macro: JTAG_READBACK_EN (tdo returns {framing_error, word_count}; otherwise bypass flop).
module jtag_deserializer #(
  parameter int DATA_WIDTH  = jtag_pkg::DATA_WIDTH,
  parameter int COUNT_WIDTH = jtag_pkg::COUNT_WIDTH
) (
  input  logic                   tck,
  input  logic                   test_logic_reset,
  input  logic                   ir_is_user,
  input  logic                   capture_dr,
  input  logic                   shift_dr,
  input  logic                   update_dr,
  input  logic                   tdi,
  output logic                   tdo,
  output logic [DATA_WIDTH-1:0]  data,
  output logic                   data_valid,
  output logic                   end_of_scan,
  output logic                   framing_error,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int               BW       = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_WIDTH - 1);

  logic shift, cap, upd;

  assign shift = ir_is_user & shift_dr;
  assign cap   = ir_is_user & capture_dr;
  assign upd   = ir_is_user & update_dr;

  logic [DATA_WIDTH-1:0]  sr_q,      sr_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  data_q,    data_d;
  logic                   dv_q,      dv_d;
  logic                   eos_q,     eos_d;
  logic                   ferr_q,    ferr_d;
  logic [COUNT_WIDTH-1:0] cnt_q,     cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    eos_d     = 1'b0;
    ferr_d    = ferr_q;
    cnt_d     = cnt_q;

    if (shift) begin
      sr_d = {tdi, sr_q[DATA_WIDTH-1:1]};
      if (bit_cnt_q == LAST_BIT) begin
        data_d    = sr_d;
        dv_d      = 1'b1;
        bit_cnt_d = '0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end else if (cap) begin
      bit_cnt_d = '0;
    end else if (upd) begin
      eos_d     = 1'b1;
      bit_cnt_d = '0;
      // A partial word is silently dropped; only the sticky flag records it.
      if (bit_cnt_q != '0) begin
        ferr_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      eos_q     <= 1'b0;
      ferr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      eos_q     <= eos_d;
      ferr_q    <= ferr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data          = data_q;
  assign data_valid    = dv_q;
  assign end_of_scan   = eos_q;
  assign framing_error = ferr_q;
  assign word_count    = cnt_q;

`ifdef JTAG_READBACK_EN
  jtag_readback_shifter #(
    .WIDTH (COUNT_WIDTH + 1)
  ) u_readback (
    .tck              (tck),
    .test_logic_reset (test_logic_reset),
    .cap_i            (cap),
    .shift_i          (shift),
    .tdi_i            (tdi),
    .load_i           ({ferr_q, cnt_q}),
    .tdo_o            (tdo)
  );
`else
  logic tdo_q;

  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      tdo_q <= 1'b0;
    end else if (shift) begin
      tdo_q <= tdi;
    end
  end

  assign tdo = tdo_q;
`endif

endmodule
